// File: rtl/cnt_date_pkg.sv
// Shared calendar definitions for the date counter: field widths, month
// constants, the packed date record and the days-in-month rule.
package cnt_date_pkg;

  localparam int DAY_W = 5;
  localparam int MON_W = 4;
  localparam int YR_W  = 7;

  localparam logic [MON_W-1:0] JAN = 4'd1;
  localparam logic [MON_W-1:0] FEB = 4'd2;
  localparam logic [MON_W-1:0] MAR = 4'd3;
  localparam logic [MON_W-1:0] APR = 4'd4;
  localparam logic [MON_W-1:0] MAY = 4'd5;
  localparam logic [MON_W-1:0] JUN = 4'd6;
  localparam logic [MON_W-1:0] JUL = 4'd7;
  localparam logic [MON_W-1:0] AUG = 4'd8;
  localparam logic [MON_W-1:0] SEP = 4'd9;
  localparam logic [MON_W-1:0] OCT = 4'd10;
  localparam logic [MON_W-1:0] NOV = 4'd11;
  localparam logic [MON_W-1:0] DEC = 4'd12;

  localparam logic [YR_W-1:0] YEAR_MAX = 7'd99;

  typedef struct packed {
    logic [DAY_W-1:0] day;
    logic [MON_W-1:0] month;
    logic [YR_W-1:0]  year;
  } date_t;

  // Within 2000-2099 every year divisible by four is a leap year (2000 included).
  // Returns 0 for an out-of-range month so no day can be valid for it.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] month,
                                                     input logic [YR_W-1:0]  year);
    logic [DAY_W-1:0] dim;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: dim = 5'd31;
      APR, JUN, SEP, NOV:                dim = 5'd30;
      FEB:     dim = ((year % YR_W'(4)) == '0) ? 5'd29 : 5'd28;
      default: dim = 5'd0;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/cnt_date_if.sv
// Date-setting and date-readout bus between the calendar stage and its user.
interface cnt_date_if;
  import cnt_date_pkg::*;

  logic             set_en;
  logic [DAY_W-1:0] set_day;
  logic [MON_W-1:0] set_month;
  logic [YR_W-1:0]  set_year;
  logic             set_ack;
  logic             set_err;
  logic [DAY_W-1:0] day;
  logic [MON_W-1:0] month;
  logic [YR_W-1:0]  year;
  logic             inc_y;

  modport master (
    output set_en, set_day, set_month, set_year,
    input  set_ack, set_err, day, month, year, inc_y
  );

  modport slave (
    input  set_en, set_day, set_month, set_year,
    output set_ack, set_err, day, month, year, inc_y
  );

endinterface

// File: rtl/cnt_date_sync_rise.sv
// Synchroniser plus rising-edge detector for a slow asynchronous carry.
// The tick is registered, and held off after reset release until the chain
// has flushed, so a carry already high at release does not look like an edge.
module cnt_date_sync_rise #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic carry,
  output logic tick
);

  localparam int unsigned ARM_CYC = SYNC_STAGES + 1;
  localparam int          ARM_W   = $clog2(ARM_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [ARM_W-1:0]       arm_q;
  logic                   armed;
  logic                   rise;

  assign armed = (arm_q == ARM_W'(ARM_CYC));
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

  // shift the asynchronous carry through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], carry};
  end

  // edge history and registered one-cycle tick, gated until armed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      prev_q <= sync_q[SYNC_STAGES-1];
      tick   <= rise & armed;
    end
  end

  // saturating count of cycles since reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      arm_q <= '0;
    else if (!armed) arm_q <= arm_q + ARM_W'(1);
  end

endmodule

// File: rtl/cnt_date.sv
// Calendar stage for 2000-2099: advances day/month/year on each rising edge
// of the hour counter's day carry, accepts validated date loads and pulses
// inc_y on the century wrap. A load in the same cycle as a tick wins and
// the tick is consumed.
module cnt_date
  import cnt_date_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_DAY     = 1,
  parameter int unsigned RST_MONTH   = 1,
  parameter int unsigned RST_YEAR    = 0
) (
  input logic        clk,
  input logic        rst_n,
  input logic        inc_d,
  cnt_date_if.slave  bus
);

  localparam date_t RST_DATE = '{day:   DAY_W'(RST_DAY),
                                 month: MON_W'(RST_MONTH),
                                 year:  YR_W'(RST_YEAR)};

  date_t cur_q;
  date_t adv;
  date_t load;
  logic  wrap;
  logic  load_ok;
  logic  day_tick;
  logic  ack_q;
  logic  err_q;
  logic  inc_y_q;

  cnt_date_sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .carry (inc_d),
    .tick  (day_tick)
  );

  // next date after one day, with century-wrap flag
  always_comb begin
    adv  = cur_q;
    wrap = 1'b0;
    if (cur_q.day < days_in_month(cur_q.month, cur_q.year)) begin
      adv.day = cur_q.day + DAY_W'(1);
    end else begin
      adv.day = DAY_W'(1);
      if (cur_q.month == DEC) begin
        adv.month = JAN;
        if (cur_q.year == YEAR_MAX) begin
          adv.year = '0;
          wrap     = 1'b1;
        end else begin
          adv.year = cur_q.year + YR_W'(1);
        end
      end else begin
        adv.month = cur_q.month + MON_W'(1);
      end
    end
  end

  // load request validation against the calendar
  always_comb begin
    load.day   = bus.set_day;
    load.month = bus.set_month;
    load.year  = bus.set_year;
    load_ok    = (bus.set_month >= JAN) && (bus.set_month <= DEC) &&
                 (bus.set_year <= YEAR_MAX) && (bus.set_day != '0) &&
                 (bus.set_day <= days_in_month(bus.set_month, bus.set_year));
  end

  // date registers and response pulses; load has priority over a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q   <= RST_DATE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      inc_y_q <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      inc_y_q <= 1'b0;
      if (bus.set_en) begin
        if (load_ok) begin
          cur_q <= load;
          ack_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end else if (day_tick) begin
        cur_q   <= adv;
        inc_y_q <= wrap;
      end
    end
  end

  assign bus.day     = cur_q.day;
  assign bus.month   = cur_q.month;
  assign bus.year    = cur_q.year;
  assign bus.set_ack = ack_q;
  assign bus.set_err = err_q;
  assign bus.inc_y   = inc_y_q;

endmodule

// File: tb/tb_cnt_date.sv
// Scoreboard bench for cnt_date: stimulus pushes expected events (cycle,
// ack/err/inc_y, resulting date) computed from a calendar model; a negedge
// monitor pops one whenever the DUT shows a pulse or a date change.
module tb_cnt_date;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inc_d = 1'b0;

  cnt_date_if bus();

  cnt_date #(.SYNC_STAGES(N), .RST_DAY(1), .RST_MONTH(1), .RST_YEAR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_d (inc_d),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit ack;
    bit err;
    bit incy;
    int d;
    int m;
    int y;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;
  int  md = 1, mm = 1, my = 0;

  function automatic int dim_ref(int m, int y);
    int yr;
    bit leap;
    yr   = 2000 + y;
    leap = ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
    case (m)
      2:           return leap ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  task automatic advance_model(output bit w);
    w = 1'b0;
    if (md < dim_ref(mm, my)) md++;
    else begin
      md = 1;
      if (mm == 12) begin
        mm = 1;
        if (my == 99) begin my = 0; w = 1'b1; end
        else my++;
      end else mm++;
    end
  endtask

  int ld = 1, lm = 1, ly = 0;
  always @(negedge clk) begin
    int cd, cm, cy;
    ev_t e;
    cd = int'(bus.day);
    cm = int'(bus.month);
    cy = int'(bus.year);
    if (!rst_n) begin
      ld = cd; lm = cm; ly = cy;
    end else if (bus.set_ack || bus.set_err || bus.inc_y || cd != ld || cm != lm || cy != ly) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d ack=%0b err=%0b inc_y=%0b date=%0d-%0d-%0d",
                 cyc, bus.set_ack, bus.set_err, bus.inc_y, cd, cm, cy);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.ack != bus.set_ack || e.err != bus.set_err ||
            e.incy != bus.inc_y || e.d != cd || e.m != cm || e.y != cy) begin
          failures++;
          $display("FAIL event got cyc=%0d ack=%0b err=%0b inc_y=%0b date=%0d-%0d-%0d expected cyc=%0d ack=%0b err=%0b inc_y=%0b date=%0d-%0d-%0d",
                   cyc, bus.set_ack, bus.set_err, bus.inc_y, cd, cm, cy,
                   e.cyc, e.ack, e.err, e.incy, e.d, e.m, e.y);
        end
      end
      ld = cd; lm = cm; ly = cy;
    end
  end

  task automatic check_date(input string name, input int d, input int m, input int y);
    checks++;
    if (int'(bus.day) != d || int'(bus.month) != m || int'(bus.year) != y) begin
      failures++;
      $display("FAIL %s got %0d-%0d-%0d expected %0d-%0d-%0d", name,
               bus.day, bus.month, bus.year, d, m, y);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (bus.set_ack !== 1'b0 || bus.set_err !== 1'b0 || bus.inc_y !== 1'b0) begin
      failures++;
      $display("FAIL %s got ack=%0b err=%0b inc_y=%0b expected all 0", name,
               bus.set_ack, bus.set_err, bus.inc_y);
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d expected 0", q.size());
      q.delete();
    end
  endtask

  // call right after a negedge; request is sampled on the next posedge
  task automatic issue_load(input int d, input int m, input int y);
    bit  ok;
    ev_t e;
    ok = (m >= 1) && (m <= 12) && (y <= 99) && (d >= 1) && (d <= dim_ref(m, y));
    bus.set_en    = 1'b1;
    bus.set_day   = 5'(d);
    bus.set_month = 4'(m);
    bus.set_year  = 7'(y);
    if (ok) begin md = d; mm = m; my = y; end
    e = '{cyc + 1, ok, !ok, 1'b0, md, mm, my};
    q.push_back(e);
  endtask

  task automatic load_once(input int d, input int m, input int y);
    @(negedge clk);
    issue_load(d, m, y);
    @(negedge clk);
    bus.set_en = 1'b0;
    drain(20);
  endtask

  task automatic pulse(input int hold);
    ev_t e;
    bit  w;
    int  c;
    @(negedge clk);
    c = cyc;
    inc_d = 1'b1;
    advance_model(w);
    e = '{c + N + 2, 1'b0, 1'b0, w, md, mm, my};
    q.push_back(e);
    repeat (hold) @(negedge clk);
    inc_d = 1'b0;
    drain(4 * N + 20);
    repeat (N + 3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int r, d, m, y, npulse;
    bus.set_en = 1'b0;
    bus.set_day = '0;
    bus.set_month = '0;
    bus.set_year = '0;

    // reset with carry already high: no false advance
    inc_d = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_date("reset_date", 1, 1, 0);
    check_quiet("reset_pulses");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_date("armed_hold", 1, 1, 0);
    inc_d = 1'b0;
    repeat (N + 3) @(negedge clk);

    // February, non-leap and leap
    load_once(28, 2, 23);
    pulse(1);
    check_date("feb_23", 1, 3, 23);
    load_once(28, 2, 24);
    pulse(3);
    check_date("feb_24_29", 29, 2, 24);
    pulse(2);
    check_date("feb_24_mar", 1, 3, 24);

    // 30-day month and invalid 31st
    load_once(30, 4, 10);
    pulse(2);
    check_date("apr_end", 1, 5, 10);
    load_once(31, 4, 10);
    check_date("apr31_reject", 1, 5, 10);

    // century wrap
    load_once(31, 12, 99);
    pulse(2);
    check_date("century", 1, 1, 0);

    // load on the tick cycle wins, tick dropped
    load_once(10, 10, 10);
    begin
      @(negedge clk);
      inc_d = 1'b1;
      @(negedge clk);
      inc_d = 1'b0;
      repeat (N - 1) @(negedge clk);
      @(negedge clk);
      issue_load(15, 6, 30);
      @(negedge clk);
      bus.set_en = 1'b0;
      drain(20);
      repeat (N + 3) @(negedge clk);
    end
    check_date("load_vs_tick", 15, 6, 30);

    // back-to-back requests, second invalid
    @(negedge clk);
    issue_load(31, 1, 50);
    @(negedge clk);
    issue_load(29, 2, 51);
    @(negedge clk);
    issue_load(0, 3, 52);
    @(negedge clk);
    bus.set_en = 1'b0;
    drain(20);

    // randomized loads and advances, biased toward month ends
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        m = $urandom_range(1, 12);
        y = ($urandom_range(0, 3) == 0) ? 99 : $urandom_range(0, 99);
        case ($urandom_range(0, 3))
          0: d = dim_ref(m, y);
          1: d = dim_ref(m, y) - 1;
          2: d = 1;
          default: d = $urandom_range(1, 31);
        endcase
      end else begin
        d = $urandom_range(0, 31);
        m = $urandom_range(0, 15);
        y = $urandom_range(0, 127);
      end
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        issue_load(d, m, y);
        @(negedge clk);
        issue_load($urandom_range(1, 28), $urandom_range(1, 12), $urandom_range(0, 99));
        @(negedge clk);
        bus.set_en = 1'b0;
        drain(20);
      end else begin
        load_once(d, m, y);
      end
      npulse = $urandom_range(0, 3);
      for (int p = 0; p < npulse; p++) pulse($urandom_range(1, 4));
    end
    check_date("random_end", md, mm, my);

    // reset asserted while a carry edge is in the synchroniser
    @(negedge clk);
    inc_d = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    md = 1; mm = 1; my = 0;
    repeat (3) @(negedge clk);
    check_date("midtick_reset", 1, 1, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    inc_d = 1'b0;
    repeat (N + 3) @(negedge clk);
    check_date("after_reset", 1, 1, 0);
    check_quiet("after_reset_pulses");

    pulse(2);
    check_date("post_reset_advance", 2, 1, 0);

    drain(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
